gpio_ext: RTL and testbench
===========================

# gpio_ext

Parametrised general-purpose I/O block with per-pin direction, input synchronisation, programmable debounce, per-pin edge/level interrupts with sticky write-1-to-clear status, and masked output writes. It sits between the processor-side valid/ready streams and the chip pads. It is the generalised successor to the 8-bit GPIO, adding arbitrary width, glitch filtering, both-edge detection and change-driven input reporting.

## Interface
- WIDTH, 8: number of pins.
- SYNC, 2: input synchroniser stages, at least 2.
- DB_W, 8: debounce counter width.

- clock  in  1  clock; all logic on rising edge.
- reset  in  1  reset; synchronous, active-high.
- din_valid  in  1  output-write request.
- din_ready  out  1  output-write accept.
- din  in  WIDTH  new output values.
- din_mask  in  WIDTH  bits to update; 1 = write.
- dout_valid  out  1  input-change snapshot available.
- dout_ready  in  1  snapshot consumed.
- dout  out  WIDTH  debounced pin snapshot.
- dout_lost  out  1  one-cycle pulse: pending snapshot overwritten.
- conf_dir  in  WIDTH  1 = output, 0 = input.
- conf_ie  in  WIDTH  per-pin interrupt enable.
- conf_mode  in  2*WIDTH  pin i uses [2i+1:2i]: 00 low level, 01 rising, 10 falling, 11 both edges.
- conf_db  in  DB_W  debounce length in cycles.
- irq_ack  in  WIDTH  write-1-to-clear status.
- irq_status  out  WIDTH  sticky pending interrupts.
- irq  out  1  OR of irq_status.
- io  inout  WIDTH  pads.

## Operation
- Reset values: out_reg 0, din_ready 0, dout_valid 0, dout 0, dout_lost 0, irq_status 0, irq 0. Synchronisers, debounce counters, stable and stable_d are cleared.
- Pad drive: io[i] = conf_dir[i] ? out_reg[i] : high-Z.
- Write path: din_ready is registered and equals |conf_dir of the previous cycle. On accept, out_reg <= (out_reg & ~din_mask) | (din & din_mask). A zero mask accepts the write without changing out_reg.
- Input path, all pins including outputs (loopback): io goes through the SYNC-stage synchroniser to produce synced, then through the debouncer.
- Debouncer, per pin:
  - If synced == stable: count <= 0.
  - Else if count >= conf_db: stable <= synced and count <= 0.
  - Else: count <= count + 1.
  - Using >= makes lowering conf_db mid-count safe.
- Edge detect: stable_d <= stable every cycle. rise = stable & ~stable_d; fall = ~stable & stable_d.
- Interrupt set condition: ev[i] = conf_ie[i] & ~conf_dir[i] & (mode-selected condition). Low-level mode fires on every cycle that stable is 0.
- Status update: irq_status <= (irq_status & ~irq_ack) | ev. If set and clear coincide, set wins. irq = |irq_status.
- Snapshot trigger: chg = |((stable ^ stable_d) & ~conf_dir).
  - On chg: dout <= stable and dout_valid <= 1.
  - If dout_valid & ~dout_ready already held, dout_lost pulses for one cycle.
  - Handshake without a simultaneous chg: dout_valid <= 0.
  - Handshake with a simultaneous chg: dout_valid stays 1, dout takes the new snapshot, no dout_lost.
- Changing conf_dir does not reset the debounce state.

## Timing
- Pad input to stable: SYNC + conf_db + 1 cycles, for a level held throughout.
- Glitches shorter than conf_db + 1 synchronised cycles are rejected.
- stable to irq_status / dout_valid: 1 cycle.
- din accept to io drive: 1 cycle.
- dout_valid remains asserted until dout_ready is sampled high.

## Structure
- gpio_pkg: mode encoding constants (MODE_LOW, MODE_RISE, MODE_FALL, MODE_BOTH).
- Sub-module gpio_debounce: one pin's synchroniser, counter and stable register, parametrised by SYNC and DB_W. Instantiated WIDTH times in a generate loop.
- Top level holds out_reg, edge detect, interrupt status and the snapshot handshake.

## Test plan
- Masked write: conf_dir = 0xFF; out_reg = 0x00; din = 0xFF, din_mask = 0x0F -> io = 0x0F one cycle after accept. With conf_dir = 0, din_ready = 0.
- Debounce: conf_db = 4, conf_dir = 0; pin 0 high for 3 cycles -> no stable change. Pin 0 held high -> stable[0] rises SYNC + 5 cycles after the io edge, and dout = 0x01 one cycle later.
- Interrupt modes: pin 1 both-edge, pin 2 falling, conf_ie = 0x06; toggle pin 1 up and down and pin 2 down -> irq_status = 0x06. irq_ack = 0x02 -> status 0x04. Ack coinciding with a new pin 2 event -> bit 2 stays set.
- Level-low: pin 3 in mode 00 held low -> irq_status[3] re-sets immediately after every ack.
- Snapshot overflow: dout_ready = 0; two separated changes -> dout holds the second value and dout_lost pulses once. Handshake with a simultaneous change -> dout_valid stays 1.
- Reset mid-debounce: assert reset during a count -> every output returns to 0 and the count restarts from 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the gpio_ext block.
// Interrupt mode encodings, one 2-bit field per pin.
package gpio_pkg;

  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin's synchroniser, glitch counter
// and stable register.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int SYNC = 2,
  parameter int DB_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pin,
  input  logic [DB_W-1:0] db,
  output logic            stable
);

  logic [SYNC-1:0] sync_q;
  logic [DB_W-1:0] count;
  logic            synced;

  assign synced = sync_q[SYNC-1];

  // shift the raw pad level through the synchroniser chain
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC-2:0], pin};
  end

  // accept a new level only after it has persisted past db cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      count  <= '0;
    end else if (count >= db) begin
      stable <= synced;
      count  <= '0;
    end else begin
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_ext.sv
// gpio_ext: parametrised GPIO with debounce, edge/level
// interrupts and change-driven input snapshots.
module gpio_ext
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC  = 2,
  parameter int DB_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   din_mask,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_lost,
  input  logic [WIDTH-1:0]   conf_dir,
  input  logic [WIDTH-1:0]   conf_ie,
  input  logic [2*WIDTH-1:0] conf_mode,
  input  logic [DB_W-1:0]    conf_db,
  input  logic [WIDTH-1:0]   irq_ack,
  output logic [WIDTH-1:0]   irq_status,
  output logic               irq,
  inout  wire  [WIDTH-1:0]   io
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] ev;
  logic             chg;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign io[i] = conf_dir[i] ? out_reg[i] : 1'bz;

    gpio_debounce #(
      .SYNC (SYNC),
      .DB_W (DB_W)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .pin    (io[i]),
      .db     (conf_db),
      .stable (stable[i])
    );
  end

  assign accept = din_valid & din_ready;
  assign rise   = stable & ~stable_d;
  assign fall   = ~stable & stable_d;
  assign ev     = conf_ie & ~conf_dir & cond;
  assign chg    = |((stable ^ stable_d) & ~conf_dir);
  assign irq    = |irq_status;

  // per-pin interrupt condition selected by its mode field
  always_comb begin
    cond = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (conf_mode[2*i +: 2])
        MODE_LOW:  cond[i] = ~stable[i];
        MODE_RISE: cond[i] = rise[i];
        MODE_FALL: cond[i] = fall[i];
        MODE_BOTH: cond[i] = rise[i] | fall[i];
      endcase
    end
  end

  // masked output writes; ready only while some pin drives
  always_ff @(posedge clock) begin
    if (reset) begin
      out_reg   <= '0;
      din_ready <= 1'b0;
    end else begin
      din_ready <= |conf_dir;
      if (accept)
        out_reg <= (out_reg & ~din_mask) | (din & din_mask);
    end
  end

  // edge history and sticky status; a new event beats an ack
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_d   <= '0;
      irq_status <= '0;
    end else begin
      stable_d   <= stable;
      irq_status <= (irq_status & ~irq_ack) | ev;
    end
  end

  // snapshot on input change; flag an unread one overwritten
  always_ff @(posedge clock) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_lost  <= 1'b0;
    end else begin
      dout_lost <= 1'b0;
      if (chg) begin
        dout       <= stable;
        dout_valid <= 1'b1;
        if (dout_valid & ~dout_ready)
          dout_lost <= 1'b1;
      end else if (dout_valid & dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_ext.sv
// tb_gpio_ext: directed vectors and corner-case
// sequences for gpio_ext.
module tb_gpio_ext;

  logic        clock = 1'b0;
  logic        reset;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  din;
  logic [7:0]  din_mask;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  dout;
  logic        dout_lost;
  logic [7:0]  conf_dir;
  logic [7:0]  conf_ie;
  logic [15:0] conf_mode;
  logic [7:0]  conf_db;
  logic [7:0]  irq_ack;
  logic [7:0]  irq_status;
  logic        irq;
  wire  [7:0]  io;

  logic [7:0]  tb_en;
  logic [7:0]  tb_val;

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign io[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_ext #(
    .WIDTH (8),
    .SYNC  (2),
    .DB_W  (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .din_mask   (din_mask),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_lost  (dout_lost),
    .conf_dir   (conf_dir),
    .conf_ie    (conf_ie),
    .conf_mode  (conf_mode),
    .conf_db    (conf_db),
    .irq_ack    (irq_ack),
    .irq_status (irq_status),
    .irq        (irq),
    .io         (io)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dir;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp_io;
  } wr_vec_t;

  wr_vec_t vecs[6];

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    din_mask   = '0;
    dout_ready = 1'b0;
    irq_ack    = '0;
    conf_ie    = '0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    conf_dir  = '0;
    conf_mode = 16'h5555;
    conf_db   = 8'd0;
    tb_en     = 8'hFF;
    tb_val    = 8'h00;
    do_reset();

    // reset state
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_lost", dout_lost, 0);
    chk("rst_irq_status", irq_status, 0);
    chk("rst_irq", irq, 0);

    // masked write vectors, out_reg accumulates across rows
    vecs[0] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F};
    vecs[1] = '{8'hFF, 8'h00, 8'h03, 8'h0C};
    vecs[2] = '{8'hFF, 8'hA5, 8'h00, 8'h0C};
    vecs[3] = '{8'hF0, 8'h5A, 8'hF0, 8'h50};
    vecs[4] = '{8'h0F, 8'hFF, 8'hFF, 8'h0F};
    vecs[5] = '{8'hFF, 8'h12, 8'hFF, 8'h12};
    for (int v = 0; v < 6; v++) begin
      conf_dir = vecs[v].dir;
      tb_en    = ~vecs[v].dir;
      tb_val   = 8'h00;
      tick();
      chk($sformatf("wr%0d_ready", v), din_ready, 1);
      din_valid = 1'b1;
      din       = vecs[v].data;
      din_mask  = vecs[v].mask;
      tick();
      din_valid = 1'b0;
      chk($sformatf("wr%0d_io", v), io, vecs[v].exp_io);
    end
    conf_dir = '0;
    tb_en    = 8'hFF;
    tick();
    chk("wr_ready_nodir", din_ready, 0);

    // debounce: short pulse rejected, held level accepted
    conf_db = 8'd4;
    do_reset();
    tick(4);
    tb_val = 8'h01;
    tick(3);
    tb_val = 8'h00;
    tick(12);
    chk("db_glitch_valid", dout_valid, 0);
    tb_val = 8'h01;
    tick(7);
    chk("db_not_yet", dout_valid, 0);
    tick();
    chk("db_valid", dout_valid, 1);
    chk("db_dout", dout, 8'h01);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("db_consumed", dout_valid, 0);

    // interrupt modes: pin1 both, pin2 falling
    conf_db   = 8'd0;
    conf_mode = 16'h556D;
    tb_val    = 8'h04;
    do_reset();
    tick(8);
    conf_ie = 8'h06;
    tb_val  = 8'h06;
    tick(6);
    tb_val  = 8'h04;
    tick(6);
    chk("irq_pin1", irq_status, 8'h02);
    tb_val = 8'h00;
    tick(6);
    chk("irq_both", irq_status, 8'h06);
    chk("irq_line", irq, 1);
    irq_ack = 8'h02;
    tick();
    irq_ack = 8'h00;
    chk("irq_ack1", irq_status, 8'h04);
    irq_ack = 8'h04;
    tick();
    irq_ack = 8'h00;
    chk("irq_ack2", irq_status, 8'h00);
    chk("irq_line_low", irq, 0);
    tb_val = 8'h04;
    tick(6);
    chk("irq_rise_ignored", irq_status, 8'h00);
    tb_val = 8'h00;
    tick(3);
    chk("irq_pre_set", irq_status, 8'h00);
    irq_ack = 8'h04;
    tick();
    irq_ack = 8'h00;
    chk("irq_set_wins", irq_status, 8'h04);

    // level-low on pin3
    conf_mode = 16'h5515;
    tb_val    = 8'h00;
    do_reset();
    tick(4);
    conf_ie = 8'h08;
    tick(2);
    chk("lvl_set", irq_status, 8'h08);
    irq_ack = 8'h08;
    tick();
    irq_ack = 8'h00;
    chk("lvl_reset_after_ack", irq_status, 8'h08);
    tb_val = 8'h08;
    tick(6);
    irq_ack = 8'h08;
    tick();
    irq_ack = 8'h00;
    chk("lvl_high_clear", irq_status, 8'h00);

    // snapshot overflow and handshake with change
    conf_mode = 16'h5555;
    tb_val    = 8'h00;
    do_reset();
    tick(4);
    tb_val = 8'h10;
    tick(4);
    chk("snap1_valid", dout_valid, 1);
    chk("snap1_dout", dout, 8'h10);
    chk("snap1_lost", dout_lost, 0);
    tick(3);
    tb_val = 8'h30;
    tick(4);
    chk("snap2_dout", dout, 8'h30);
    chk("snap2_lost", dout_lost, 1);
    tick();
    chk("snap2_lost_once", dout_lost, 0);
    chk("snap2_valid", dout_valid, 1);
    tick(2);
    tb_val = 8'h70;
    tick(3);
    dout_ready = 1'b1;
    tick();
    chk("hs_chg_valid", dout_valid, 1);
    chk("hs_chg_dout", dout, 8'h70);
    chk("hs_chg_lost", dout_lost, 0);
    tick();
    dout_ready = 1'b0;
    chk("hs_done", dout_valid, 0);

    // reset in the middle of a debounce count
    conf_mode = 16'h5515;
    conf_db   = 8'd4;
    conf_dir  = 8'h80;
    tb_en     = 8'h7F;
    tb_val    = 8'h00;
    do_reset();
    tick();
    din_valid = 1'b1;
    din       = 8'h80;
    din_mask  = 8'h80;
    conf_ie   = 8'h08;
    tick();
    din_valid = 1'b0;
    tick(2);
    chk("mid_pre_io", io[7], 1);
    chk("mid_pre_irq", irq, 1);
    tb_val = 8'h01;
    tick(4);
    reset   = 1'b1;
    conf_ie = 8'h00;
    tick();
    reset = 1'b0;
    chk("mid_din_ready", din_ready, 0);
    chk("mid_irq_status", irq_status, 0);
    chk("mid_irq", irq, 0);
    chk("mid_dout_valid", dout_valid, 0);
    chk("mid_dout", dout, 0);
    chk("mid_io7", io[7], 0);
    tick(7);
    chk("mid_restart_wait", dout_valid, 0);
    tick();
    chk("mid_restart_valid", dout_valid, 1);
    chk("mid_restart_dout", dout, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
